dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage of the MIPS pipeline. It serves the load/store request from EX/MEM. It returns readData and the hit/ready flag that the MEM/WB register uses as its load enable. Misses are refilled from main memory with a 4-word burst over a req/ready handshake.

---
 rtl/dcache_ctrl_if.sv | 33 +++
 rtl/dcache_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Purpose : bundles the pipeline request/response and memory burst signals of dcache_ctrl.
// Latency : none, wires only.
// Backpres: hit stalls the pipeline; memReady paces the memory side.
// Ports   : pipeline side address/writeData/memRead/memWrite -> readData/hit;
//           memory side memReq/memWe/memAddr/memWriteData -> memReady/memReadData.
// Modports: master = the cache controller (it masters the memory bus and
//           answers the pipeline); slave = the pipeline stage plus main memory.
interface dcache_ctrl_if;
  // pipeline (EX/MEM -> cache -> MEM/WB)
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] readData;
  logic        hit;
  // main memory
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memReady;
  logic [31:0] memReadData;

  modport master (
    input  address, writeData, memRead, memWrite, memReady, memReadData,
    output readData, hit, memReq, memWe, memAddr, memWriteData
  );

  modport slave (
    output address, writeData, memRead, memWrite, memReady, memReadData,
    input  readData, hit, memReq, memWe, memAddr, memWriteData
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Purpose : direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Latency : hit 0 cycles; read miss 4 memReady beats + 1; store 1 memReady beat + 1 (WDONE).
// Backpres: hit=0 stalls the pipeline; every memory beat waits for memReady, no timeout.
// Ports   : clk, rst (async, active-high); bus = dcache_ctrl_if.master carrying the
//           pipeline request (address, writeData, memRead, memWrite), the response
//           (readData, hit) and the registered memory burst port.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.master bus
);

  localparam int LINE_WORDS = 4;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int TAG_W      = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    COMPARE,
    REFILL,
    WRITE,
    WDONE
  } state_t;

  state_t state, state_nxt;

  // storage; only the valid bits are reset
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES][LINE_WORDS];

  // refill beat counter, also the word slot being filled
  logic [1:0] cnt;

  // registered memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // combinational pipeline response
  logic        hit;
  logic [31:0] read_data;

  // address decode; byte offset is irrelevant to a word cache
  logic [1:0]            word;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic                  line_hit;
  logic                  last_beat;
  logic                  unused_byte_offset;

  assign word               = bus.address[3:2];
  assign index              = bus.address[3+INDEX_BITS:4];
  assign tag                = bus.address[31:4+INDEX_BITS];
  assign unused_byte_offset = ^bus.address[1:0];
  assign line_hit           = valid[index] && (tag_arr[index] == tag);
  assign last_beat          = (cnt == 2'd3);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COMPARE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and pipeline response
  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    read_data = '0;
    case (state)
      COMPARE: begin
        read_data = data_arr[index][word];
        if (bus.memWrite) begin
          // stores always go to memory; they win over a simultaneous load
          state_nxt = WRITE;
        end else if (bus.memRead) begin
          if (line_hit) begin
            hit = 1'b1;
          end else begin
            state_nxt = REFILL;
          end
        end else begin
          // no request: let the pipeline advance
          hit = 1'b1;
        end
      end
      REFILL: begin
        if (bus.memReady && last_beat) begin
          state_nxt = COMPARE;
        end
      end
      WRITE: begin
        if (bus.memReady) begin
          state_nxt = WDONE;
        end
      end
      WDONE: begin
        // single completion pulse for the store; the next request is
        // judged in COMPARE so the store is never reissued
        hit       = 1'b1;
        state_nxt = COMPARE;
      end
      default: state_nxt = COMPARE;
    endcase
  end

  // memory port, valid bits and refill counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= '0;
      cnt       <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (bus.memWrite) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {bus.address[31:2], 2'b00};
            mem_wdata <= bus.writeData;
          end else if (bus.memRead && !line_hit) begin
            cnt      <= 2'd0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {tag, index, 4'b0000};
          end
        end
        REFILL: begin
          if (bus.memReady) begin
            cnt <= cnt + 2'd1;
            if (last_beat) begin
              // line becomes visible only once complete, so an aborted
              // burst can never leave a half-filled valid line
              valid[index] <= 1'b1;
              mem_req      <= 1'b0;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        WRITE: begin
          if (bus.memReady) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // tag and data arrays: no reset, written only from REFILL/WRITE, which
  // reset leaves immediately
  always_ff @(posedge clk) begin
    if (state == REFILL && bus.memReady) begin
      data_arr[index][cnt] <= bus.memReadData;
      if (last_beat) begin
        tag_arr[index] <= tag;
      end
    end
    // write-through: update only a resident line, never allocate
    if (state == WRITE && bus.memReady && line_hit) begin
      data_arr[index][word] <= bus.writeData;
    end
  end

  assign bus.hit          = hit;
  assign bus.readData     = read_data;
  assign bus.memReq       = mem_req;
  assign bus.memWe        = mem_we;
  assign bus.memAddr      = mem_addr;
  assign bus.memWriteData = mem_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Purpose : scoreboard bench for dcache_ctrl; directed requests push expected
//           memory beats and hit data, independent monitors pop and compare.
// Ports   : none; drives a dcache_ctrl_if instance and a simple memory model.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  beat_t       mem_q[$];
  logic [31:0] hit_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int ready_gap   = 0;
  int wait_cnt    = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push_refill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      mem_q.push_back('{addr: base + 32'(4 * i), we: 1'b0, wdata: 32'h0});
    end
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    mem_q.push_back('{addr: addr, we: 1'b1, wdata: data});
  endtask

  // memory model: word at A is 0x1000+A; memReady after ready_gap idle cycles.
  // A beat raised at a negedge is accepted by the DUT on the following posedge.
  initial begin
    beat_t b;
    bus.memReady    = 1'b0;
    bus.memReadData = 32'h0;
    forever begin
      @(negedge clk);
      if (rst || !bus.memReq) begin
        bus.memReady = 1'b0;
        wait_cnt     = 0;
      end else if (wait_cnt < ready_gap) begin
        bus.memReady = 1'b0;
        wait_cnt++;
      end else begin
        bus.memReady    = 1'b1;
        wait_cnt        = 0;
        bus.memReadData = 32'h1000 + bus.memAddr;
        if (mem_q.size() == 0) begin
          flag("unexpected_mem_beat");
        end else begin
          b = mem_q.pop_front();
          check32("mem_addr", bus.memAddr, b.addr);
          check32("mem_we", {31'b0, bus.memWe}, {31'b0, b.we});
          if (b.we) check32("mem_wdata", bus.memWriteData, b.wdata);
        end
      end
    end
  end

  // pipeline monitor: a completed request is hit=1 while a request is held
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.hit && (bus.memRead || bus.memWrite)) begin
        if (hit_q.size() == 0) flag("unexpected_hit");
        else check32("read_data", bus.readData, hit_q.pop_front());
      end
    end
  end

  // issue one request, wait (bounded) for hit, check negedges-to-hit, then release
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_data, input int exp_lat);
    int n   = 0;
    bit got = 1'b0;
    hit_q.push_back(exp_data);
    bus.address   = addr;
    bus.writeData = wdata;
    bus.memRead   = rd;
    bus.memWrite  = wr;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      got = bus.hit;
    end
    if (!got) flag("hit_timeout");
    else check32("hit_latency", 32'(n), 32'(exp_lat));
    @(posedge clk);
    #1;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.address   = 32'h0;
    bus.writeData = 32'h0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_memReq", {31'b0, bus.memReq}, 32'h0);
    check32("rst_memWe", {31'b0, bus.memWe}, 32'h0);
    check32("rst_memAddr", bus.memAddr, 32'h0);
    check32("rst_memWriteData", bus.memWriteData, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check32("idle_hit", {31'b0, bus.hit}, 32'h1);
    @(posedge clk);
    #1;

    // cold read miss: 4-beat refill from 0x40
    push_refill(32'h40);
    req(1'b1, 1'b0, 32'h40, 32'h0, 32'h1040, 6);
    // same line, other word: same-cycle hit, no memory traffic
    req(1'b1, 1'b0, 32'h48, 32'h0, 32'h1048, 1);

    // store to a resident line with memReady delayed 3 cycles
    ready_gap = 3;
    push_write(32'h44, 32'hDEADBEEF);
    req(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 32'h0, 6);
    ready_gap = 0;
    req(1'b1, 1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 1);

    // store miss: written through without allocation, so the read refills
    push_write(32'h300, 32'h12345678);
    req(1'b0, 1'b1, 32'h300, 32'h12345678, 32'h0, 3);
    push_refill(32'h300);
    req(1'b1, 1'b0, 32'h300, 32'h0, 32'h1300, 6);

    // reset after two refill beats of 0x80
    mem_q.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0});
    mem_q.push_back('{addr: 32'h84, we: 1'b0, wdata: 32'h0});
    bus.address = 32'h80;
    bus.memRead = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("abort_memAddr", bus.memAddr, 32'h88);
    rst = 1'b1;
    #1;
    check32("abort_memReq", {31'b0, bus.memReq}, 32'h0);
    repeat (2) @(negedge clk);
    check32("abort_memReq_held", {31'b0, bus.memReq}, 32'h0);
    push_refill(32'h80);
    rst = 1'b0;
    req(1'b1, 1'b0, 32'h80, 32'h0, 32'h1080, 5);

    // index conflict after reset: three full refills
    push_refill(32'h40);
    req(1'b1, 1'b0, 32'h40, 32'h0, 32'h1040, 6);
    push_refill(32'h140);
    req(1'b1, 1'b0, 32'h140, 32'h0, 32'h1140, 6);
    push_refill(32'h40);
    req(1'b1, 1'b0, 32'h4C, 32'h0, 32'h104C, 6);

    repeat (4) @(negedge clk);
    check32("mem_q_left", 32'(mem_q.size()), 32'h0);
    check32("hit_q_left", 32'(hit_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
